// File: rtl/issue_sb_multiport.sv
// In-order multi-issue tracker: tags issued instructions, collects tagged write-backs, retires in order.
// Build option ISSUE_SB_WB_BYPASS_EN forwards same-cycle write-backs straight to the commit outputs.

module issue_sb_entry #(
    parameter int DataWidth = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 alloc_i,
    input  logic [4:0]           alloc_rd_i,
    input  logic                 alloc_we_i,
    input  logic                 wb_i,
    input  logic [DataWidth-1:0] wb_data_i,
    input  logic                 wb_ex_i,
    input  logic                 retire_i,
    output logic                 live_o,
    output logic                 done_o,
    output logic                 ex_o,
    output logic                 we_o,
    output logic [4:0]           rd_o,
    output logic [DataWidth-1:0] data_o
);
    logic                 live_q, live_d;
    logic                 done_q, done_d;
    logic                 ex_q, ex_d;
    logic                 we_q, we_d;
    logic [4:0]           rd_q, rd_d;
    logic [DataWidth-1:0] data_q, data_d;

    always_comb begin
        live_d = live_q;
        done_d = done_q;
        ex_d   = ex_q;
        we_d   = we_q;
        rd_d   = rd_q;
        data_d = data_q;
        if (clear_i) begin
            live_d = 1'b0;
            done_d = 1'b0;
        end else begin
            if (retire_i) live_d = 1'b0;
            if (wb_i) begin
                done_d = 1'b1;
                data_d = wb_data_i;
                ex_d   = wb_ex_i;
            end
            // allocation only targets free slots, so it never collides with retire or write-back
            if (alloc_i) begin
                live_d = 1'b1;
                done_d = 1'b0;
                ex_d   = 1'b0;
                we_d   = alloc_we_i;
                rd_d   = alloc_rd_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            live_q <= 1'b0;
            done_q <= 1'b0;
            ex_q   <= 1'b0;
            we_q   <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
        end else begin
            live_q <= live_d;
            done_q <= done_d;
            ex_q   <= ex_d;
            we_q   <= we_d;
            rd_q   <= rd_d;
            data_q <= data_d;
        end
    end

    assign live_o = live_q;
    assign done_o = done_q;
    assign ex_o   = ex_q;
    assign we_o   = we_q;
    assign rd_o   = rd_q;
    assign data_o = data_q;
endmodule

module issue_sb_multiport #(
    parameter int  NrEntries     = 8,
    parameter int  IssueWidth    = 2,
    parameter int  NrWbPorts     = 4,
    parameter int  NrCommitPorts = 2,
    parameter int  DataWidth     = 64,
    localparam int TagWidth      = $clog2(NrEntries)
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    flush_i,
    input  logic [IssueWidth-1:0]                   issue_valid_i,
    input  logic [IssueWidth-1:0][4:0]              issue_rd_i,
    input  logic [IssueWidth-1:0]                   issue_we_i,
    output logic [IssueWidth-1:0]                   issue_ready_o,
    output logic [IssueWidth-1:0][TagWidth-1:0]     issue_tag_o,
    input  logic [NrWbPorts-1:0]                    wb_valid_i,
    input  logic [NrWbPorts-1:0][TagWidth-1:0]      wb_tag_i,
    input  logic [NrWbPorts-1:0][DataWidth-1:0]     wb_data_i,
    input  logic [NrWbPorts-1:0]                    wb_ex_i,
    output logic [31:0]                             busy_gpr_o,
    output logic [NrCommitPorts-1:0]                commit_valid_o,
    output logic [NrCommitPorts-1:0][TagWidth-1:0]  commit_tag_o,
    output logic [NrCommitPorts-1:0][4:0]           commit_rd_o,
    output logic [NrCommitPorts-1:0]                commit_we_o,
    output logic [NrCommitPorts-1:0][DataWidth-1:0] commit_data_o,
    output logic [NrCommitPorts-1:0]                commit_ex_o,
    input  logic [NrCommitPorts-1:0]                commit_ack_i,
    output logic                                    full_o,
    output logic                                    empty_o,
    output logic [TagWidth:0]                       count_o
);
    localparam int                  CntWidth = TagWidth + 1;
    localparam logic [CntWidth-1:0] Depth    = CntWidth'(NrEntries);

    logic [TagWidth-1:0] issue_ptr_q, issue_ptr_d;
    logic [TagWidth-1:0] commit_ptr_q, commit_ptr_d;
    logic [CntWidth-1:0] count_q, count_d;
    logic [CntWidth-1:0] free_slots, n_fire, n_ret;

    logic [NrEntries-1:0]                al_vld, al_we;
    logic [NrEntries-1:0][4:0]           al_rd;
    logic [NrEntries-1:0]                wb_hit, wb_ex_sel, retire;
    logic [NrEntries-1:0][DataWidth-1:0] wb_data_sel;
    logic [NrEntries-1:0]                e_live, e_done, e_ex, e_we;
    logic [NrEntries-1:0][4:0]           e_rd;
    logic [NrEntries-1:0][DataWidth-1:0] e_data;

    for (genvar e = 0; e < NrEntries; e++) begin : g_entry
        issue_sb_entry #(.DataWidth(DataWidth)) u_entry (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .clear_i    (flush_i),
            .alloc_i    (al_vld[e]),
            .alloc_rd_i (al_rd[e]),
            .alloc_we_i (al_we[e]),
            .wb_i       (wb_hit[e]),
            .wb_data_i  (wb_data_sel[e]),
            .wb_ex_i    (wb_ex_sel[e]),
            .retire_i   (retire[e]),
            .live_o     (e_live[e]),
            .done_o     (e_done[e]),
            .ex_o       (e_ex[e]),
            .we_o       (e_we[e]),
            .rd_o       (e_rd[e]),
            .data_o     (e_data[e])
        );
    end

    // issue: lanes fire as a contiguous prefix starting at lane 0
    always_comb begin
        logic                chain;
        logic [TagWidth-1:0] tag;
        free_slots = Depth - count_q;
        n_fire     = '0;
        al_vld     = '0;
        al_we      = '0;
        al_rd      = '0;
        chain      = 1'b1;
        for (int k = 0; k < IssueWidth; k++) begin
            tag              = issue_ptr_q + TagWidth'(k);
            issue_ready_o[k] = free_slots > CntWidth'(k);
            issue_tag_o[k]   = tag;
            chain            = chain & issue_valid_i[k] & issue_ready_o[k];
            if (chain) begin
                n_fire      = n_fire + CntWidth'(1);
                al_vld[tag] = 1'b1;
                al_we[tag]  = issue_we_i[k];
                al_rd[tag]  = issue_rd_i[k];
            end
        end
    end

    // write-back: scan ports high to low so the lowest matching port wins
    always_comb begin
        wb_hit      = '0;
        wb_data_sel = '0;
        wb_ex_sel   = '0;
        for (int e = 0; e < NrEntries; e++) begin
            for (int p = NrWbPorts - 1; p >= 0; p--) begin
                if (wb_valid_i[p] && (wb_tag_i[p] == TagWidth'(e)) && e_live[e]) begin
                    wb_hit[e]      = 1'b1;
                    wb_data_sel[e] = wb_data_i[p];
                    wb_ex_sel[e]   = wb_ex_i[p];
                end
            end
        end
    end

    always_comb begin
        logic                 vchain, achain, done_k, ex_k;
        logic [DataWidth-1:0] data_k;
        logic [TagWidth-1:0]  idx;
        commit_valid_o = '0;
        commit_tag_o   = '0;
        commit_rd_o    = '0;
        commit_we_o    = '0;
        commit_data_o  = '0;
        commit_ex_o    = '0;
        retire         = '0;
        n_ret          = '0;
        vchain         = 1'b1;
        achain         = 1'b1;
        for (int k = 0; k < NrCommitPorts; k++) begin
            idx = commit_ptr_q + TagWidth'(k);
`ifdef ISSUE_SB_WB_BYPASS_EN
            done_k = e_done[idx] | wb_hit[idx];
            data_k = wb_hit[idx] ? wb_data_sel[idx] : e_data[idx];
            ex_k   = wb_hit[idx] ? wb_ex_sel[idx] : e_ex[idx];
`else
            done_k = e_done[idx];
            data_k = e_data[idx];
            ex_k   = e_ex[idx];
`endif
            vchain            = vchain & e_live[idx] & done_k;
            commit_valid_o[k] = vchain;
            // fields read as zero on ports that are not presenting an entry
            if (vchain) begin
                commit_tag_o[k]  = idx;
                commit_rd_o[k]   = e_rd[idx];
                commit_we_o[k]   = e_we[idx];
                commit_data_o[k] = data_k;
                commit_ex_o[k]   = ex_k;
            end
            achain = achain & vchain & commit_ack_i[k];
            if (achain) begin
                retire[idx] = 1'b1;
                n_ret       = n_ret + CntWidth'(1);
            end
        end
    end

    always_comb begin
        busy_gpr_o = '0;
        for (int e = 0; e < NrEntries; e++) begin
            if (e_live[e] && e_we[e]) busy_gpr_o[e_rd[e]] = 1'b1;
        end
        busy_gpr_o[0] = 1'b0;
    end

    always_comb begin
        issue_ptr_d  = issue_ptr_q + TagWidth'(n_fire);
        commit_ptr_d = commit_ptr_q + TagWidth'(n_ret);
        count_d      = count_q + n_fire - n_ret;
        if (flush_i) begin
            issue_ptr_d  = '0;
            commit_ptr_d = '0;
            count_d      = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            issue_ptr_q  <= '0;
            commit_ptr_q <= '0;
            count_q      <= '0;
        end else begin
            issue_ptr_q  <= issue_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            count_q      <= count_d;
        end
    end

    assign count_o = count_q;
    assign full_o  = (count_q == Depth);
    assign empty_o = (count_q == '0);
endmodule
